seq_chunk_adder: RTL



---
 rtl/seq_chunk_adder_pkg.sv | 20 ++
 rtl/seq_chunk_adder_chunk_add.sv | 23 ++
 rtl/seq_chunk_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunk cycles needed to cover a full-width operand.
    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Width of the chunk index counter, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// One CHUNK-bit slice of the adder: a + b + ci. On the final, possibly
// narrower chunk the carry is taken from bit LAST_W, which works because
// the unused upper operand bits are zero.
module chunk_add #(
    parameter int CHUNK  = 3,
    parameter int LAST_W = CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    input  logic             last_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);
    import seq_add_pkg::*;

    logic [CHUNK:0] full;

    assign full = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
    assign s_o  = full[CHUNK-1:0];
    assign co_o = last_i ? full[LAST_W] : full[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock with the
// carry rippled through a register, valid/ready on both sides.
// Optional macro ADDER_SUB_EN adds a 'sub' input selecting a - b - cin.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    import seq_add_pkg::*;

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MASK     = WIDTH'({CHUNK{1'b1}});

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;

    logic [WIDTH-1:0] b_eff, sum_d;
    logic             cin_eff, ovf_d, last, co;
    logic [CHUNK-1:0] a_chunk, b_chunk, s;
    int               shamt;

`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ^ cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last = (idx_q == LAST_IDX);

    // Select the current chunk of each operand and merge its sum back in place.
    always_comb begin
        shamt   = int'(idx_q) * CHUNK;
        a_chunk = CHUNK'(a_q >> shamt);
        b_chunk = CHUNK'(b_q >> shamt);
        sum_d   = (sum_q & ~(MASK << shamt)) | (WIDTH'(s) << shamt);
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    chunk_add #(
        .CHUNK  (CHUNK),
        .LAST_W (LAST_W)
    ) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .ci_i   (carry_q),
        .last_i (last),
        .s_o    (s),
        .co_o   (co)
    );

    // Control FSM: accept operands, ripple one chunk per cycle, hold result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= co;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q  <= co;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
